deselect_16: RTL and testbench
==============================

# deselect_16

Receive-side counterpart of the 16-input, one-bit-per-slot serializer. The block samples the serial bit and start marker once per `time_025` slot, and rebuilds the 16-bit parallel word. It flags each complete word with a one-cycle valid pulse. It also detects framing loss, meaning a start marker that is missing or arrives early, and resynchronizes to the next start slot.

## Interface
- `DATA_W`, 16: bits per frame. The serializer fixes this at 16, so no other value is supported.
- `ERRCNT_W`, 8: width of the error counter. Only used when `DESELECT16_ERRCNT_EN` is defined.
- `clk_in`  input  1  system clock; every register is on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `time_025`  input  1  slot timing signal, the same one that drives the serializer. Each transition ends one slot.
- `start_in`  input  1  start marker from the serializer; 1 during slot 0 of each frame.
- `ser_in`  input  1  serial data from the serializer; carries `in[k]` during slot k, for k = 1..16.
- `data_out`  output  [16:1]  last complete word; `data_out[k]` = bit received in slot k. Reset value 0.
- `data_valid`  output  1  one-cycle pulse when `data_out` updates. Reset value 0.
- `frame_err`  output  1  one-cycle pulse on a framing violation. Reset value 0.
- `locked`  output  1  1 in states RECV and WAIT_START, 0 in IDLE. Reset value 0.
- `err_cnt`  output  [ERRCNT_W-1:0]  saturating count of `frame_err` pulses. Present only when the macro is defined. Reset value 0.

## Operation
- Tick event:
  - `time_025` passes through a two-flop register chain (q1, q2).
  - `tick = q1 ^ q2`, so both edges of `time_025` count as ticks.
  - This matches the serializer's slot advance exactly.
- On the clock edge where `tick` = 1, the block samples `start_in` and `ser_in`. At that edge they still carry the values of the slot that is ending.
- A 5-bit slot index `idx` (range 1..16) holds the position in the frame. A 16-bit shift/assembly register `shreg` holds the bits collected so far.
- FSM, with all transitions taken only on tick edges:
  - IDLE (hunt):
    - `start_in`=1 → RECV, with `idx`=1.
    - Otherwise stay in IDLE. No error is raised.
  - RECV, normal case (`start_in`=0):
    - `shreg[idx]` ← `ser_in`.
    - If `idx`=16: load `data_out` ← {`ser_in`, `shreg[15:1]`} in bit order, pulse `data_valid`, go to WAIT_START.
    - Otherwise `idx` ← `idx`+1.
  - RECV, early start (`start_in`=1):
    - Pulse `frame_err`.
    - Discard the partial word; `data_out` is unchanged.
    - Stay in RECV with `idx`=1. The block resynchronizes to this start.
  - WAIT_START:
    - `start_in`=1 → RECV, with `idx`=1.
    - `start_in`=0 → pulse `frame_err`, go to IDLE.
- `ser_in` is ignored during any start slot. The serializer drives X there.
- `shreg` is not cleared between frames. Every bit is overwritten before it is used.

## Timing
- Tick latency: a `time_025` transition is registered into q1 at edge n, and `tick` is high from n to n+1. The sampling action occurs at edge n+1.
- `data_valid` and the new `data_out` appear together at the edge that samples slot 16. `data_out` holds that value until the next valid frame completes.
- `data_valid`, `frame_err` and `err_cnt` increments are all exactly one clock wide. They coincide with the tick edge that caused them.
- `data_valid` and `frame_err` never assert in the same cycle.
- Frame period is 17 slots: 1 start slot plus 16 data slots. Back-to-back frames give WAIT_START → RECV with no gap slot.
- Reset mid-frame: the asynchronous reset forces every output and q1, q2, `idx`, `shreg` and the FSM to their reset values immediately. After release, the block is in IDLE and hunting.
- `start_in` and `ser_in` are in the `clk_in` domain and are not synchronized. `time_025` may be asynchronous; the two-flop chain handles it.

## Configuration
- `DESELECT16_ERRCNT_EN` defined:
  - The `err_cnt` port and counter exist.
  - The counter increments on every `frame_err` pulse and saturates at all-ones; it does not wrap.
  - Only `reset` clears it.
- `DESELECT16_ERRCNT_EN` undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Structure
- Shared package `sel16_pkg` contains:
  - FSM state encoding: IDLE=2'd0, RECV=2'd1, WAIT_START=2'd2.
  - Constants `SEL16_DATA_W`=16 and `SEL16_SLOTS`=17.
  - `sel16_idx_t`, a 5-bit slot index type.
  - The serializer is to use the same package.
- One sub-module, `tick_edge_det`: the q1/q2 chain plus the XOR, emitting `tick`. The serializer's edge detection will reuse it.

## Test plan
- Reset values: hold `reset`=0 with toggling inputs → `data_out`=16'h0000, `data_valid`=0, `frame_err`=0, `locked`=0, `err_cnt`=0.
- Single frame:
  - Stimulus: start slot, then the bits of 16'hA5C3 in slots 1..16.
  - Required: exactly one `data_valid` pulse, at the slot-16 tick edge, with `data_out`=16'hA5C3 and `locked`=1 afterwards.
- Back-to-back frames:
  - Stimulus: frames 16'hFFFF, 16'h0001, 16'h8000 with no gaps.
  - Required: three `data_valid` pulses spaced 17 ticks apart, carrying the correct words, and no `frame_err`.
- Early start:
  - Stimulus: `start_in`=1 in slot 7, then a full clean frame 16'h1234.
  - Required: one `frame_err` pulse at the slot-7 tick, `data_out` unchanged at that point, then `data_valid` with 16'h1234.
- Missing start:
  - Stimulus: a clean frame followed by one slot with `start_in`=0.
  - Required: `frame_err` pulse, `locked`=0 (IDLE), and no `data_valid` until the next start plus 16 slots.
- Reset mid-frame and saturation:
  - Stimulus: assert `reset` during slot 9 → all outputs return to 0 immediately, and the next full frame decodes correctly.
  - With `DESELECT16_ERRCNT_EN` defined: 300 consecutive early starts → `err_cnt`=8'hFF and held there.

Source files
------------

// File: rtl/sel16_pkg.sv
// Shared definitions for the 16-slot serializer / deserializer pair:
// FSM encoding, frame geometry and the slot index type.
package sel16_pkg;

  localparam int SEL16_DATA_W = 16;
  localparam int SEL16_SLOTS  = 17;

  typedef logic [4:0] sel16_idx_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RECV       = 2'd1,
    WAIT_START = 2'd2
  } sel16_state_t;

  localparam sel16_idx_t SEL16_FIRST_IDX = 5'd1;
  localparam sel16_idx_t SEL16_LAST_IDX  = 5'(SEL16_DATA_W);

endpackage

// File: rtl/deselect_16_if.sv
// Serial-side inputs and parallel-side outputs of deselect_16.
// err_cnt exists only when DESELECT16_ERRCNT_EN is defined.
interface deselect_16_if #(
  parameter int DATA_W = 16
`ifdef DESELECT16_ERRCNT_EN
  , parameter int ERRCNT_W = 8
`endif
) ();

  logic              time_025;
  logic              start_in;
  logic              ser_in;
  logic [DATA_W:1]   data_out;
  logic              data_valid;
  logic              frame_err;
  logic              locked;
`ifdef DESELECT16_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt;
`endif

  // Serializer / stimulus side.
  modport master (
    output time_025, start_in, ser_in,
    input  data_out, data_valid, frame_err, locked
`ifdef DESELECT16_ERRCNT_EN
    , input err_cnt
`endif
  );

  // Deserializer side.
  modport slave (
    input  time_025, start_in, ser_in,
    output data_out, data_valid, frame_err, locked
`ifdef DESELECT16_ERRCNT_EN
    , output err_cnt
`endif
  );

endinterface

// File: rtl/tick_edge_det.sv
// Two-flop capture of the slot timing signal; tick pulses for one clock on
// every transition (both edges). Shared with the serializer.
module tick_edge_det (
  input  logic clk_in,
  input  logic reset,
  input  logic level,
  output logic tick
);

  logic q1;
  logic q2;

  // NOTE: sequential state uses non-blocking assignments so q2 sees the old q1.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      q1 <= level;
      q2 <= q1;
    end
  end

  assign tick = q1 ^ q2;

endmodule

// File: rtl/deselect_16.sv
// 16-slot serial-to-parallel receiver with start-marker framing and resync.
// Optional saturating frame error counter: define DESELECT16_ERRCNT_EN.
module deselect_16
  import sel16_pkg::*;
#(
  parameter int DATA_W = SEL16_DATA_W
`ifdef DESELECT16_ERRCNT_EN
  , parameter int ERRCNT_W = 8
`endif
) (
  input  logic          clk_in,
  input  logic          reset,
  deselect_16_if.slave  bus
);

  logic            tick;
  sel16_state_t    state;
  sel16_idx_t      idx;
  logic [DATA_W:1] shreg;
  logic [DATA_W:1] data_q;
  logic            valid_q;
  logic            err_q;
  logic            locked_q;
  logic            err_now;

  tick_edge_det u_tick (
    .clk_in (clk_in),
    .reset  (reset),
    .level  (bus.time_025),
    .tick   (tick)
  );

  // A start while collecting is an early start; no start after a full word is
  // a missing start. Both are framing errors.
  always_comb begin
    err_now = 1'b0;
    if (tick) begin
      err_now = ((state == RECV) && bus.start_in) ||
                ((state == WAIT_START) && !bus.start_in);
    end
  end

  // NOTE: shreg is cleared by the async reset too, so no state can survive a
  // mid-frame reset even though every bit is rewritten before use.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= SEL16_FIRST_IDX;
      shreg    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= err_now;
      if (tick) begin
        case (state)
          IDLE: begin
            if (bus.start_in) begin
              state    <= RECV;
              idx      <= SEL16_FIRST_IDX;
              locked_q <= 1'b1;
            end
          end
          RECV: begin
            if (bus.start_in) begin
              // Resync to this start; the partial word is dropped.
              idx <= SEL16_FIRST_IDX;
            end else begin
              shreg[idx] <= bus.ser_in;
              if (idx == SEL16_LAST_IDX) begin
                data_q  <= {bus.ser_in, shreg[DATA_W-1:1]};
                valid_q <= 1'b1;
                state   <= WAIT_START;
              end else begin
                idx <= idx + 5'd1;
              end
            end
          end
          WAIT_START: begin
            if (bus.start_in) begin
              state <= RECV;
              idx   <= SEL16_FIRST_IDX;
            end else begin
              state    <= IDLE;
              locked_q <= 1'b0;
            end
          end
          default: begin
            state    <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = err_q;
  assign bus.locked     = locked_q;

`ifdef DESELECT16_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else if (err_now && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_deselect_16.sv
// Randomized self-checking bench for deselect_16 against a slot-level model.
module tb_deselect_16;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;

  always #5 clk_in = ~clk_in;

  deselect_16_if bus ();

  deselect_16 dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: bits collected since the last accepted start.
  // -1 = hunting for a start, 0..15 = collecting, 16 = word done, start due.
  int          m_nbits;
  logic [16:1] m_word;
  logic [16:1] m_data;
  int          m_err;
  bit          e_dv;
  bit          e_fe;
  int          m_dv_total = 0;
  int          m_fe_total = 0;
  int          dv_seen = 0;
  int          fe_seen = 0;

  task automatic model_reset();
    m_nbits = -1;
    m_word  = '0;
    m_data  = '0;
    m_err   = 0;
  endtask

  task automatic model_slot(input bit s, input bit d);
    e_dv = 1'b0;
    e_fe = 1'b0;
    if (m_nbits < 0) begin
      if (s) m_nbits = 0;
    end else if (s) begin
      if (m_nbits != 16) e_fe = 1'b1;
      m_nbits = 0;
    end else if (m_nbits == 16) begin
      e_fe    = 1'b1;
      m_nbits = -1;
    end else begin
      m_word[m_nbits + 1] = d;
      m_nbits++;
      if (m_nbits == 16) begin
        e_dv   = 1'b1;
        m_data = m_word;
      end
    end
    if (e_fe && m_err < 255) m_err++;
    if (e_dv) m_dv_total++;
    if (e_fe) m_fe_total++;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".dv"},     bus.data_valid, e_dv);
    check({tag, ".fe"},     bus.frame_err,  e_fe);
    check({tag, ".data"},   bus.data_out,   m_data);
    check({tag, ".locked"}, bus.locked,     m_nbits >= 0);
`ifdef DESELECT16_ERRCNT_EN
    check({tag, ".errcnt"}, bus.err_cnt,    m_err);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".dv"},     bus.data_valid, 0);
    check({tag, ".fe"},     bus.frame_err,  0);
    check({tag, ".data"},   bus.data_out,   0);
    check({tag, ".locked"}, bus.locked,     0);
`ifdef DESELECT16_ERRCNT_EN
    check({tag, ".errcnt"}, bus.err_cnt,    0);
`endif
  endtask

  // One slot: present values, end the slot with a time_025 transition, and
  // check right after the clock edge that samples the ending slot.
  task automatic drive_slot(input bit s, input bit d, input string tag);
    @(negedge clk_in);
    bus.start_in = s;
    bus.ser_in   = d;
    repeat (2) @(negedge clk_in);
    bus.time_025 = ~bus.time_025;
    @(negedge clk_in);
    model_slot(s, d);
    @(negedge clk_in);
    check_outputs(tag);
  endtask

  task automatic send_frame(input logic [16:1] w, input string tag);
    drive_slot(1'b1, 1'($urandom), tag);
    for (int k = 1; k <= 16; k++) drive_slot(1'b0, w[k], tag);
  endtask

  always @(negedge clk_in) begin
    if (bus.data_valid) dv_seen++;
    if (bus.frame_err)  fe_seen++;
  end

  initial begin
    bus.time_025 = 1'b0;
    bus.start_in = 1'b0;
    bus.ser_in   = 1'b0;
    model_reset();

    // Reset held with toggling inputs.
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      bus.time_025 = 1'($urandom);
      bus.start_in = 1'($urandom);
      bus.ser_in   = 1'($urandom);
      if (i % 5 == 4) check_all_zero("reset_hold");
    end
    @(negedge clk_in);
    bus.start_in = 1'b0;
    bus.time_025 = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk_in);

    // Single frame.
    send_frame(16'hA5C3, "single");

    // Back-to-back frames.
    send_frame(16'hFFFF, "b2b0");
    send_frame(16'h0001, "b2b1");
    send_frame(16'h8000, "b2b2");
    check("b2b.fe_total", fe_seen, 0);

    // Early start in slot 7, then a clean frame.
    drive_slot(1'b1, 1'b0, "early");
    for (int k = 1; k <= 6; k++) drive_slot(1'b0, 1'($urandom), "early");
    drive_slot(1'b1, 1'b0, "early7");
    for (int k = 1; k <= 16; k++) drive_slot(1'b0, k[0] ^ k[2], "early_rest");
    drive_slot(1'b0, 1'b0, "to_idle");
    send_frame(16'h1234, "after_early");

    // Missing start, a few idle slots, then a fresh frame.
    drive_slot(1'b0, 1'b1, "missing");
    drive_slot(1'b0, 1'b1, "hunt");
    drive_slot(1'b0, 1'b0, "hunt");
    send_frame(16'h5A5A, "relock");

    // Reset during slot 9.
    drive_slot(1'b1, 1'b0, "pre_rst");
    for (int k = 1; k <= 8; k++) drive_slot(1'b0, 1'($urandom), "pre_rst");
    @(negedge clk_in);
    bus.start_in = 1'b0;
    bus.ser_in   = 1'b1;
    #2 reset = 1'b0;
    #1 check_all_zero("mid_rst");
    model_reset();
    repeat (3) @(negedge clk_in);
    reset = 1'b1;
    repeat (4) @(negedge clk_in);
    send_frame(16'hC0DE, "post_rst");

    // Random slot stream: nominal 17-slot framing with start bits flipped.
    for (int i = 0; i < 340; i++) begin
      bit s;
      s = (i % 17 == 0);
      if ($urandom_range(0, 9) == 0) s = ~s;
      drive_slot(s, 1'($urandom), "rand");
    end

`ifdef DESELECT16_ERRCNT_EN
    // Saturation: a run of starts, each one early after the first.
    for (int i = 0; i < 300; i++) drive_slot(1'b1, 1'b0, "sat");
    check("sat.final", bus.err_cnt, 8'hFF);
    drive_slot(1'b1, 1'b0, "sat_hold");
`endif

    repeat (4) @(negedge clk_in);
    check("dv_total", dv_seen, m_dv_total);
    check("fe_total", fe_seen, m_fe_total);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
